immediateencoder: RTL and testbench
===================================

# immediateencoder

Inverse of `immediategenerator`. It accepts a 32-bit immediate value, an `ImmSrc` format code, and the non-immediate instruction fields. It scatters the immediate into RISC-V instruction bits [31:7] and flags values the format cannot represent. The block is a 2-stage valid/ready pipeline feeding the instruction-memory loader and self-check harness of the single-cycle core, so assembled words round-trip through `immediategenerator`.

## Interface
- `ERR_CNT_W`, 16, width of saturating error counter
- `clk`  in  1  clock, all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  input beat present
- `in_ready`  out  1  block accepts beat this cycle
- `imm`  in  32  immediate value (two's complement)
- `ImmSrc`  in  3  format: 000 I, 001 S, 010 U, 101 B, 110 J; others illegal
- `rest_31_7`  in  25  non-immediate fields (rd/rs1/rs2/funct3), same bit positions as output
- `out_valid`  out  1  output beat present
- `out_ready`  in  1  downstream accepts
- `instruction_31_7`  out  25  packed instruction bits [31:7] (index k ↔ instr bit k+7)
- `out_range_err`  out  1  immediate not representable in the format
- `out_illegal`  out  1  `ImmSrc` not a defined code
- `err_count`  out  ERR_CNT_W  number of delivered beats with either error flag set

## Operation
- Packing uses output index = instruction bit − 7. Bits not listed come from `rest_31_7`.
  - I: out[24:13]=imm[11:0].
  - S: out[24:18]=imm[11:5], out[4:0]=imm[4:0].
  - U: out[24:5]=imm[31:12].
  - B: out[24]=imm[12], out[23:18]=imm[10:5], out[4:1]=imm[4:1], out[0]=imm[11].
  - J: out[24]=imm[20], out[23:14]=imm[10:1], out[13]=imm[11], out[12:5]=imm[19:12].
- Range rules:
  - I/S: imm[31:11] all equal.
  - U: imm[11:0]==0.
  - B: imm[31:12] all equal and imm[0]==0.
  - J: imm[31:20] all equal and imm[0]==0.
- A violating beat is still packed with truncated bits and flagged `out_range_err`=1.
- Illegal `ImmSrc`: `instruction_31_7`=`rest_31_7`, `out_illegal`=1, `out_range_err`=0.
- Stage 1 registers the inputs and computes the flags. Stage 2 registers the packed word and flags.
- `err_count` increments on `out_valid && out_ready && (out_range_err || out_illegal)`. It saturates at all-ones and never wraps.

## Timing
- Reset (async assert, sync-safe deassert): both stage valids 0, all data and flag registers 0, `err_count` 0. `in_ready`=1 during and after reset.
- A beat is accepted on `in_valid && in_ready`. With `out_ready` held high, `out_valid` rises 2 cycles after acceptance, with 1 beat/cycle sustained throughput.
- Stage 1 advances when stage 2 is empty or `out_ready`=1. `in_ready` = !s1_valid || s1 advances. This is combinational from `out_ready`, with no bubble on simultaneous pop and push.
- Stall: while `out_valid && !out_ready`, all output ports hold stable. At most 2 beats are buffered, then `in_ready`=0.
- Ordering is strict FIFO. No beat is dropped or duplicated.
- Reset mid-operation discards buffered beats immediately. `err_count` clears.
- Counter saturation is reached by a delivered error beat; subsequent error beats leave the count unchanged.

## Structure
- Shared package `immgen_pkg` holds `IMM_I`, `IMM_S`, `IMM_U`, `IMM_B`, `IMM_J` localparams, also consumed by `immediategenerator`.
- Sub-module `immediateencoder_pack` is the purely combinational packer plus range checker (imm, ImmSrc, rest → word, range_err, illegal), instantiated in stage 1.
- The top level contains the pipeline registers, handshake logic and counter.

## Test plan
- I, imm=0xFFFFF800, rest=0 → after 2 cycles out[24:13]=0x800, out[12:0]=0, no flags. Same with imm=0x00000800 → `out_range_err`=1, `err_count`=1.
- U, imm=0xABCDE000, rest=0x0000A (rd=x10 in out[4:0]) → out[24:5]=0xABCDE, out[4:0]=0x0A. Same with imm=0xABCDE001 → range_err.
- B, imm=0x00000FFE → out[24]=0, out[23:18]=0x3F, out[4:1]=0xF, out[0]=1. J, imm=0xFFF00000 → out[24]=1, other imm bits 0, no flags. J, imm=0x3 → range_err.
- ImmSrc=3'b011, rest=0x1ABCDEF → `instruction_31_7`=0x1ABCDEF, `out_illegal`=1.
- Backpressure: 5 back-to-back beats with `out_ready` toggled 1,0,0,1… → `in_ready` drops after 2 buffered, outputs stable while stalled, all 5 delivered in order. Assert `rst_n` with 2 buffered → `out_valid`=0 and `err_count`=0 immediately.
- Round trip: random legal (imm, format) pairs → `immediategenerator` output equals the original imm (B/J compare imm with bit 0 cleared). `ERR_CNT_W`=2 with 5 error beats → `err_count` sticks at 3.

Source files
------------

// File: rtl/immgen_pkg.sv
// Shared immediate-format codes and helpers for the immediate generator/encoder pair.
// Pure definitions; no state and no timing.
package immgen_pkg;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_U = 3'b010;
   localparam logic [2:0] IMM_B = 3'b101;
   localparam logic [2:0] IMM_J = 3'b110;

   typedef struct packed {
      logic [31:0] imm;
      logic [2:0]  imm_src;
      logic [24:0] rest;
   } enc_in_t;

   typedef struct packed {
      logic [24:0] word;
      logic        range_err;
      logic        illegal;
   } enc_out_t;

   // True when v is a sign-extended value of the given width (bits >= 1).
   function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
      logic [31:0] s;
      s = $signed(v) >>> (bits - 1);
      return (s == '0) || (s == '1);
   endfunction

endpackage

// File: rtl/immediateencoder_pack.sv
// Combinational scatter of an immediate into instruction bits [31:7] plus range/format checks.
// Zero latency; no handshake.
module immediateencoder_pack
   import immgen_pkg::*;
(
   input  logic [31:0] imm,
   input  logic [2:0]  imm_src,
   input  logic [24:0] rest,
   output logic [24:0] word,
   output logic        range_err,
   output logic        illegal
);

   always_comb begin
      word      = rest;
      range_err = 1'b0;
      illegal   = 1'b0;
      case (imm_src)
         IMM_I: begin
            word[24:13] = imm[11:0];
            range_err   = !fits_signed(imm, 12);
         end
         IMM_S: begin
            word[24:18] = imm[11:5];
            word[4:0]   = imm[4:0];
            range_err   = !fits_signed(imm, 12);
         end
         IMM_U: begin
            word[24:5] = imm[31:12];
            range_err  = |imm[11:0];
         end
         IMM_B: begin
            word[24]    = imm[12];
            word[23:18] = imm[10:5];
            word[4:1]   = imm[4:1];
            word[0]     = imm[11];
            range_err   = !fits_signed(imm, 13) || imm[0];
         end
         IMM_J: begin
            word[24]    = imm[20];
            word[23:14] = imm[10:1];
            word[13]    = imm[11];
            word[12:5]  = imm[19:12];
            range_err   = !fits_signed(imm, 21) || imm[0];
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/immediateencoder.sv
// Two-stage valid/ready immediate encoder: output 2 cycles after accept, 1 beat/cycle.
// Backpressure: stages hold under !out_ready; in_ready drops once both stages are full.
module immediateencoder
   import immgen_pkg::*;
#(
   parameter int ERR_CNT_W = 16
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          imm,
   input  logic [2:0]           ImmSrc,
   input  logic [24:0]          rest_31_7,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [24:0]          instruction_31_7,
   output logic                 out_range_err,
   output logic                 out_illegal,
   output logic [ERR_CNT_W-1:0] err_count
);

   logic     s1_valid;
   enc_in_t  s1;
   logic     s2_valid;
   enc_out_t s2;
   enc_out_t packed_s1;
   logic     s2_adv;
   logic     deliver_err;

   immediateencoder_pack u_pack (
      .imm       (s1.imm),
      .imm_src   (s1.imm_src),
      .rest      (s1.rest),
      .word      (packed_s1.word),
      .range_err (packed_s1.range_err),
      .illegal   (packed_s1.illegal)
   );

   // Stage 2 frees up whenever it is empty or being popped, so a pop and push can coincide.
   assign s2_adv   = !s2_valid || out_ready;
   assign in_ready = !s1_valid || s2_adv;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1       <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1.imm     <= imm;
            s1.imm_src <= ImmSrc;
            s1.rest    <= rest_31_7;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2       <= '0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2 <= packed_s1;
         end
      end
   end

   assign out_valid        = s2_valid;
   assign instruction_31_7 = s2.word;
   assign out_range_err    = s2.range_err;
   assign out_illegal      = s2.illegal;

   assign deliver_err = s2_valid && out_ready && (s2.range_err || s2.illegal);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count <= '0;
      end else if (deliver_err && (err_count != '1)) begin
         err_count <= err_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_immediateencoder.sv
// Randomized scoreboard bench for immediateencoder with a reference encoder/decoder model.
module tb_immediateencoder;
   localparam int CW = 2;
   localparam int CMAX = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   imm;
   logic [2:0]    ImmSrc;
   logic [24:0]   rest_31_7;
   logic          out_valid;
   logic          out_ready;
   logic [24:0]   instruction_31_7;
   logic          out_range_err;
   logic          out_illegal;
   logic [CW-1:0] err_count;

   immediateencoder #(.ERR_CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .imm(imm), .ImmSrc(ImmSrc), .rest_31_7(rest_31_7),
      .out_valid(out_valid), .out_ready(out_ready),
      .instruction_31_7(instruction_31_7), .out_range_err(out_range_err),
      .out_illegal(out_illegal), .err_count(err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [24:0] word;
      logic        rerr;
      logic        ill;
      logic [31:0] imm;
      logic [2:0]  src;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   fails = 0;
   int   model_cnt = 0;
   int   ready_mode = 0;   // 0: always 1, 1: random, 2: 1,0,0 pattern, 3: held 0
   int   pat = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference encoder written in instruction-bit order (bits 31..7).
   function automatic exp_t model(input logic [31:0] i, input logic [2:0] s, input logic [24:0] r);
      exp_t e;
      longint v;
      v = longint'($signed(i));
      e.imm = i; e.src = s; e.ill = 1'b0; e.rerr = 1'b0; e.word = r;
      case (s)
         3'b000: begin e.word = {i[11:0], r[12:0]}; e.rerr = (v < -2048) || (v > 2047); end
         3'b001: begin e.word = {i[11:5], r[17:5], i[4:0]}; e.rerr = (v < -2048) || (v > 2047); end
         3'b010: begin e.word = {i[31:12], r[4:0]}; e.rerr = (i % 4096) != 0; end
         3'b101: begin
            e.word = {i[12], i[10:5], r[17:5], i[4:1], i[11]};
            e.rerr = (v < -4096) || (v > 4095) || (i % 2 != 0);
         end
         3'b110: begin
            e.word = {i[20], i[10:1], i[11], i[19:12], r[4:0]};
            e.rerr = (v < -(1 <<< 20)) || (v > (1 <<< 20) - 1) || (i % 2 != 0);
         end
         default: e.ill = 1'b1;
      endcase
      return e;
   endfunction

   // Reference immediate generator (decoder) for round-trip checks.
   function automatic logic [31:0] gen(input logic [24:0] w, input logic [2:0] s);
      logic [31:0] ins;
      ins = {w, 7'b0};
      case (s)
         3'b000:  return {{20{ins[31]}}, ins[31:20]};
         3'b001:  return {{20{ins[31]}}, ins[31:25], ins[11:7]};
         3'b010:  return {ins[31:12], 12'b0};
         3'b101:  return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         3'b110:  return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         default: return 32'h0;
      endcase
   endfunction

   always @(negedge clk) begin
      case (ready_mode)
         0: out_ready = 1'b1;
         1: out_ready = ($urandom % 4) != 0;
         2: begin out_ready = (pat == 0); pat = (pat + 1) % 3; end
         default: out_ready = 1'b0;
      endcase
   end

   // Monitor: compares every delivered beat and checks hold-stability under stall.
   initial begin
      logic        hold;
      logic [24:0] pw;
      logic        pr, pi;
      exp_t        e;
      hold = 1'b0; pw = '0; pr = 1'b0; pi = 1'b0;
      forever begin
         @(negedge clk);
         #3;
         if (!rst_n) begin
            hold = 1'b0;
         end else begin
            if (hold) begin
               chk("stall_valid", 64'(out_valid), 64'd1);
               chk("stall_word", 64'(instruction_31_7), 64'(pw));
               chk("stall_flags", 64'({out_range_err, out_illegal}), 64'({pr, pi}));
            end
            chk("err_count", 64'(err_count), 64'(model_cnt));
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  chk("unexpected_beat", 64'd1, 64'd0);
               end else begin
                  e = sb.pop_front();
                  chk("word", 64'(instruction_31_7), 64'(e.word));
                  chk("range_err", 64'(out_range_err), 64'(e.rerr));
                  chk("illegal", 64'(out_illegal), 64'(e.ill));
                  if (!e.rerr && !e.ill)
                     chk("round_trip", 64'(gen(instruction_31_7, e.src)),
                         64'((e.src == 3'b101 || e.src == 3'b110) ? (e.imm & ~32'd1) : e.imm));
                  if ((e.rerr || e.ill) && model_cnt < CMAX) model_cnt++;
               end
            end
            hold = out_valid && !out_ready;
            pw = instruction_31_7; pr = out_range_err; pi = out_illegal;
         end
      end
   end

   task automatic send(input logic [31:0] i, input logic [2:0] s, input logic [24:0] r);
      int n;
      n = 0;
      imm = i; ImmSrc = s; rest_31_7 = r; in_valid = 1'b1;
      #1;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (in_ready) sb.push_back(model(i, s, r));
      else chk("in_ready_timeout", 64'd0, 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", 64'(sb.size()), 64'd0);
      @(negedge clk);
   endtask

   function automatic logic [31:0] legal_imm(input logic [2:0] s);
      logic [31:0] r;
      r = $urandom;
      case (s)
         3'b000, 3'b001: return {{20{r[11]}}, r[11:0]};
         3'b010:         return {r[31:12], 12'b0};
         3'b101:         return {{19{r[12]}}, r[12:1], 1'b0};
         default:        return {{11{r[20]}}, r[20:1], 1'b0};
      endcase
   endfunction

   initial begin
      logic [2:0] fmts [5];
      logic [2:0] s;
      fmts[0] = 3'b000; fmts[1] = 3'b001; fmts[2] = 3'b010; fmts[3] = 3'b101; fmts[4] = 3'b110;
      rst_n = 1'b0; in_valid = 1'b0; imm = '0; ImmSrc = '0; rest_31_7 = '0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_err_count", 64'(err_count), 64'd0);
      chk("rst_word", 64'(instruction_31_7), 64'd0);
      chk("rst_flags", 64'({out_range_err, out_illegal}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed beats.
      send(32'hFFFFF800, 3'b000, 25'h0);
      send(32'h00000800, 3'b000, 25'h0);
      send(32'hABCDE000, 3'b010, 25'h0000A);
      send(32'hABCDE001, 3'b010, 25'h0000A);
      send(32'h00000FFE, 3'b101, 25'h0);
      send(32'hFFF00000, 3'b110, 25'h0);
      send(32'h00000003, 3'b110, 25'h0);
      send(32'h12345678, 3'b011, 25'h1ABCDEF);
      send(32'hFFFFF7FF, 3'b001, 25'h1FFFFFF);
      drain();

      // Backpressure: fill both stages, then confirm in_ready drops.
      ready_mode = 3;
      @(negedge clk);
      send(32'h00000010, 3'b000, 25'h00123);
      send(32'h00000020, 3'b001, 25'h00456);
      imm = 32'h30; ImmSrc = 3'b010; in_valid = 1'b1;
      #1;
      chk("in_ready_full", 64'(in_ready), 64'd0);
      in_valid = 1'b0;
      @(negedge clk);
      pat = 0;
      ready_mode = 2;
      send(32'h00003000, 3'b010, 25'h00789);
      send(32'h00000040, 3'b101, 25'h00ABC);
      send(32'h00000080, 3'b110, 25'h00DEF);
      drain();

      // Reset with two beats buffered.
      ready_mode = 3;
      @(negedge clk);
      send(32'h00001000, 3'b000, 25'h0);
      send(32'h00000005, 3'b011, 25'h0);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_err_count", 64'(err_count), 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      sb.delete();
      model_cnt = 0;
      ready_mode = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Five error beats: counter must saturate at 3.
      for (int k = 0; k < 5; k++) send(32'h00000001, 3'b101, 25'($urandom));
      drain();
      chk("sat_count", 64'(err_count), 64'(CMAX));

      // Randomized mix under random backpressure.
      ready_mode = 1;
      for (int k = 0; k < 400; k++) begin
         case ($urandom % 4)
            0, 1: begin s = fmts[$urandom % 5]; send(legal_imm(s), s, 25'($urandom)); end
            2:    send($urandom, fmts[$urandom % 5], 25'($urandom));
            default: send($urandom, 3'($urandom), 25'($urandom));
         endcase
      end
      ready_mode = 0;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
